// File: rtl/multi_digit_timer.sv
// ---------------------------------------------------------------------------
// multi_digit_timer
//
// A programmable BCD timer with a tick prescaler and a seven-segment decode
// for each digit. Every TICK_DIV clock cycles of enabled time, the count
// moves one step. The direction and end-of-count behaviour depend on mode.
//
// Parameters
//   NUM_DIGITS  number of BCD digits (1..8)
//   TICK_DIV    clk cycles per tick (>= 2)
//
// Ports
//   clk         system clock, rising-edge active
//   rst         asynchronous active-low reset
//   enable      prescaler runs while high and holds while low
//   reconfig    synchronous load strobe for count and reload value
//   load_value  BCD load/reload value, digit 0 in bits [3:0]
//   mode        00 down-stop, 01 down-reload, 10 up-wrap, 11 hold
//   tick        one-cycle pulse in the last cycle of each tick interval
//   count       current BCD count, digit 0 in bits [3:0]
//   segments    active-high seven-segment codes, digit i in [7i+6:7i]
//   expired     one-cycle pulse after a terminal event
//   done        level, set when a down-stop countdown reaches zero
// ---------------------------------------------------------------------------
module multi_digit_timer #(
    parameter int NUM_DIGITS = 2,
    parameter int TICK_DIV   = 50000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    reconfig,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic [1:0]              mode,
    output logic                    tick,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic [7*NUM_DIGITS-1:0] segments,
    output logic                    expired,
    output logic                    done
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(TICK_DIV);

    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] BCD_ONE   = CW'(1);
    localparam logic [CW-1:0] ALL_NINES = {NUM_DIGITS{4'd9}};

    localparam logic [1:0] MODE_DOWN_STOP   = 2'b00;
    localparam logic [1:0] MODE_DOWN_RELOAD = 2'b01;
    localparam logic [1:0] MODE_UP_WRAP     = 2'b10;

    logic [PW-1:0] presc_q,   presc_d;
    logic [CW-1:0] count_q,   count_d;
    logic [CW-1:0] reload_q,  reload_d;
    logic          done_q,    done_d;
    logic          expired_q, expired_d;

    // Any digit above 9 is forced to 9 so the count is always valid BCD.
    function automatic logic [CW-1:0] clamp_bcd(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // BCD decrement with ripple borrow. The caller never passes zero.
    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // BCD increment with ripple carry. All nines wraps to zero because the
    // final carry is dropped.
    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic [CW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Segment order is bit0 = a through bit6 = g, active high.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    assign tick = enable && (presc_q == PRESC_MAX);

    always_comb begin
        presc_d   = presc_q;
        count_d   = count_q;
        reload_d  = reload_q;
        done_d    = done_q;
        expired_d = 1'b0;

        if (reconfig) begin
            // A load wins over a coincident tick. It also restarts the
            // tick interval.
            presc_d  = '0;
            count_d  = clamp_bcd(load_value);
            reload_d = clamp_bcd(load_value);
            done_d   = 1'b0;
        end else begin
            if (enable) begin
                presc_d = (presc_q == PRESC_MAX) ? '0 : presc_q + PW'(1);
            end

            if (tick) begin
                case (mode)
                    MODE_DOWN_STOP: begin
                        if (count_q != '0) begin
                            count_d = bcd_dec(count_q);
                            if (count_q == BCD_ONE) begin
                                expired_d = 1'b1;
                                done_d    = 1'b1;
                            end
                        end
                    end
                    MODE_DOWN_RELOAD: begin
                        if (count_q == '0) begin
                            count_d   = reload_q;
                            expired_d = 1'b1;
                        end else begin
                            count_d = bcd_dec(count_q);
                        end
                    end
                    MODE_UP_WRAP: begin
                        count_d = bcd_inc(count_q);
                        if (count_q == ALL_NINES) begin
                            expired_d = 1'b1;
                        end
                    end
                    default: begin
                        count_d = count_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            reload_q  <= '0;
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

    always_comb begin
        segments = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            segments[7*i +: 7] = seg7(count_q[4*i +: 4]);
        end
    end

    assign count   = count_q;
    assign done    = done_q;
    assign expired = expired_q;

endmodule
